// File: rtl/traffic_phase_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : traffic_phase_timer                                        |
// | Description : Phase timer for traffic_fsm. A prescaler builds 1 s ticks  |
// |               and a per-phase countdown is loaded from the FSM phase     |
// |               code. It drives second_cnt_pre_last / light_cnt_last back  |
// |               to the FSM.                                                |
// |               Optional feature macro: TRAFFIC_PED_EXTEND_EN (pedestrian  |
// |               extension of the RED phase, granted once per phase).       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module traffic_phase_timer #(
  parameter int CLK_PER_SEC       = 1000,
  parameter int LIGHT_STATE_WIDTH = 3,
  parameter int LIGHT_CNT_WIDTH   = 8,
  parameter int GREEN_TIME        = 30,
  parameter int YELLOW_TIME       = 3,
  parameter int RED_TIME          = 33,
  parameter int PED_EXTRA         = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         restart,
  input  logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init,
  input  logic                         ped_req,
  output logic                         second_cnt_pre_last,
  output logic                         sec_tick,
  output logic                         light_cnt_last,
  output logic [LIGHT_CNT_WIDTH-1:0]   light_cnt_val,
  output logic                         init_err
);

  localparam int SEC_W = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;

  localparam logic [SEC_W-1:0]             c_sec_pre    = SEC_W'(CLK_PER_SEC - 2);
  localparam logic [SEC_W-1:0]             c_sec_last   = SEC_W'(CLK_PER_SEC - 1);
  localparam logic [LIGHT_CNT_WIDTH-1:0]   c_green      = LIGHT_CNT_WIDTH'(GREEN_TIME);
  localparam logic [LIGHT_CNT_WIDTH-1:0]   c_yellow     = LIGHT_CNT_WIDTH'(YELLOW_TIME);
  localparam logic [LIGHT_CNT_WIDTH-1:0]   c_red        = LIGHT_CNT_WIDTH'(RED_TIME);
  localparam logic [LIGHT_CNT_WIDTH-1:0]   c_one        = LIGHT_CNT_WIDTH'(1);
  localparam logic [LIGHT_STATE_WIDTH-1:0] c_code_green = LIGHT_STATE_WIDTH'(1);
  localparam logic [LIGHT_STATE_WIDTH-1:0] c_code_yel   = LIGHT_STATE_WIDTH'(2);
  localparam logic [LIGHT_STATE_WIDTH-1:0] c_code_red   = LIGHT_STATE_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [SEC_W-1:0]           sec_q, sec_d;
  logic [LIGHT_CNT_WIDTH-1:0] light_q, light_d;
  logic                       pre_last_q, pre_last_d;
  logic                       tick_q, tick_d;
  logic                       last_q, last_d;
  logic                       err_q, err_d;

  logic [LIGHT_CNT_WIDTH-1:0] w_dur;
  logic                       w_code_bad;
  logic                       w_advance;
  logic                       w_reload;
  logic [LIGHT_CNT_WIDTH-1:0] w_light_ext;

  // Phase code to duration; anything not one-hot GREEN/YELLOW/RED falls back to RED.
  always_comb begin
    w_dur      = c_red;
    w_code_bad = 1'b0;
    case (light_cnt_init)
      c_code_green: w_dur = c_green;
      c_code_yel:   w_dur = c_yellow;
      c_code_red:   w_dur = c_red;
      default:      w_code_bad = 1'b1;
    endcase
  end

  // Control FSM and counter next-state; every load (IDLE start or restart) happens on entry to LOAD.
  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    light_d   = light_q;
    err_d     = 1'b0;
    w_advance = 1'b0;
    w_reload  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (restart)  state_d = S_LOAD;
        else if (en)  state_d = S_RUN;
        else          state_d = S_PAUSE;
      end
      S_RUN: begin
        if (restart)  state_d = S_LOAD;
        else if (!en) state_d = S_PAUSE;
        else          w_advance = 1'b1;
      end
      S_PAUSE: begin
        if (restart)  state_d = S_LOAD;
        else if (en)  state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_LOAD) begin
      sec_d   = '0;
      light_d = w_dur;
      err_d   = w_code_bad;
    end else if (w_advance) begin
      if (sec_q == c_sec_last) begin
        sec_d = '0;
        if (light_q == c_one) begin
          // Phase ends: the FSM has already presented the next phase code.
          light_d  = w_dur;
          err_d    = w_code_bad;
          w_reload = 1'b1;
        end else begin
          light_d = light_q - c_one;
        end
      end else begin
        sec_d = sec_q + SEC_W'(1);
      end
    end
  end

`ifdef TRAFFIC_PED_EXTEND_EN
  logic                       grant_q, grant_d;
  logic [LIGHT_CNT_WIDTH:0]   w_sum;

  // One saturating RED extension per phase; a reload into RED may take the request at once.
  always_comb begin
    grant_d     = grant_q;
    w_light_ext = light_d;
    w_sum       = {1'b0, light_d} + (LIGHT_CNT_WIDTH+1)'(PED_EXTRA);
    if ((state_d == S_LOAD) || w_reload) grant_d = 1'b0;
    if (w_advance && ped_req && (light_cnt_init == c_code_red) && (!grant_q || w_reload)) begin
      w_light_ext = w_sum[LIGHT_CNT_WIDTH] ? '1 : w_sum[LIGHT_CNT_WIDTH-1:0];
      grant_d     = 1'b1;
    end
  end

  // Grant flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_q <= 1'b0;
    else        grant_q <= grant_d;
  end
`else
  logic w_unused_ped;
  assign w_unused_ped = ped_req;
  assign w_light_ext  = light_d;
`endif

  // Status flags are decoded from the next counter values so they line up with the counters.
  always_comb begin
    pre_last_d = (state_d == S_RUN) && (sec_d == c_sec_pre);
    tick_d     = (state_d == S_RUN) && (sec_d == c_sec_last);
    last_d     = (state_d == S_RUN) && (w_light_ext == c_one);
  end

  // State, counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sec_q      <= '0;
      light_q    <= '0;
      pre_last_q <= 1'b0;
      tick_q     <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      light_q    <= w_light_ext;
      pre_last_q <= pre_last_d;
      tick_q     <= tick_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  assign second_cnt_pre_last = pre_last_q;
  assign sec_tick            = tick_q;
  assign light_cnt_last      = last_q;
  assign light_cnt_val       = light_q;
  assign init_err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_traffic_phase_timer                                     |
// | Description : Self-checking bench for traffic_phase_timer against a      |
// |               behavioural per-second countdown model.                    |
// |               Honours TRAFFIC_PED_EXTEND_EN when defined.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_traffic_phase_timer;

  localparam int CPS = 4;
  localparam int GT  = 3;
  localparam int YT  = 2;
  localparam int RT  = 4;
  localparam int PX  = 2;
`ifdef TRAFFIC_PED_EXTEND_EN
  localparam int EXT_VAL = 5;
`else
  localparam int EXT_VAL = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       restart = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] init_code = 3'b001;
  logic       pre_last, tick, last, err;
  logic [7:0] val;
  logic [11:0] dut_bus;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: mode of operation, seconds position, seconds remaining.
  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_PAUSE} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_sec = 0;
  int     m_rem = 0;
  bit     m_err = 1'b0;
  bit     m_granted = 1'b0;

  always #5 clk = ~clk;

  traffic_phase_timer #(
    .CLK_PER_SEC(CPS), .LIGHT_STATE_WIDTH(3), .LIGHT_CNT_WIDTH(8),
    .GREEN_TIME(GT), .YELLOW_TIME(YT), .RED_TIME(RT), .PED_EXTRA(PX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
    .light_cnt_init(init_code), .ped_req(ped_req),
    .second_cnt_pre_last(pre_last), .sec_tick(tick), .light_cnt_last(last),
    .light_cnt_val(val), .init_err(err)
  );

  assign dut_bus = {pre_last, tick, last, val, err};

  function automatic int dur_of(input logic [2:0] c);
    case (c)
      3'b001:  return GT;
      3'b010:  return YT;
      default: return RT;
    endcase
  endfunction

  function automatic bit code_ok(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
  endfunction

  function automatic logic [2:0] next_code(input logic [2:0] c);
    case (c)
      3'b001:  return 3'b010;
      3'b010:  return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [11:0] exp_bus();
    bit r;
    r = (m_mode == M_RUN);
    return {r && (m_sec == CPS-2), r && (m_sec == CPS-1), r && (m_rem == 1), 8'(m_rem), m_err};
  endfunction

  function automatic bit fsm_switch();
    return (m_mode == M_RUN) && (m_rem == 1) && (m_sec == CPS-2);
  endfunction

  // Applies one clock edge of the behavioural rules to the model.
  task automatic model_step();
    bit do_load, advance, reload;
    do_load = 0; advance = 0; reload = 0; m_err = 0;
    if (m_mode == M_IDLE)       do_load = en;
    else if (restart)           do_load = 1;
    else if (m_mode == M_LOAD)  m_mode = en ? M_RUN : M_PAUSE;
    else if (m_mode == M_RUN) begin
      if (!en) m_mode = M_PAUSE;
      else     advance = 1;
    end else if (en)            m_mode = M_RUN;

    if (do_load) begin
      m_mode = M_LOAD; m_sec = 0; m_rem = dur_of(init_code);
      m_err = !code_ok(init_code); m_granted = 0;
    end
    if (advance) begin
      if (m_sec == CPS-1) begin
        if (m_rem == 1) begin
          reload = 1; m_rem = dur_of(init_code); m_err = !code_ok(init_code);
        end else begin
          m_rem = m_rem - 1;
        end
      end
      m_sec = (m_sec + 1) % CPS;
    end
`ifdef TRAFFIC_PED_EXTEND_EN
    if (reload) m_granted = 0;
    if (advance && ped_req && (init_code == 3'b100) && !m_granted) begin
      m_rem = (m_rem + PX > 255) ? 255 : m_rem + PX;
      m_granted = 1;
    end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_sec = 0; m_rem = 0; m_err = 0; m_granted = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; restart = 1'b0; ped_req = 1'b0; init_code = 3'b001;
    #12;
    checks++;
    if (dut_bus !== 12'h000) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_bus, 12'h000);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_bus !== 12'h000) begin
        errors++; $display("FAIL idle_hold cyc=%0d got=%h exp=%h", cyc, dut_bus, 12'h000);
      end
    end
  endtask

  task automatic test_phase_loop();
    int last_cnt, g1, g2;
    bit green_done, seen_one;
    logic [7:0] prev;
    last_cnt = 0; g1 = -1; g2 = -1; green_done = 0; seen_one = 0;
    en = 1'b1; init_code = 3'b001;
    step();
    checks++;
    if (val !== 8'd3 || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL load_green got=%h exp=%h", dut_bus, exp_bus());
    end
    prev = val;
    for (int i = 0; i < 90; i++) begin
      step();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++; $display("FAIL phase_loop cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
      if (!green_done) begin
        if (last) last_cnt++;
        if (val == 8'd1) seen_one = 1;
        if (seen_one && val == 8'd2) green_done = 1;
      end
      if (prev == 8'd1 && val == 8'd3) begin
        if (g1 < 0) g1 = cyc;
        else if (g2 < 0) g2 = cyc;
      end
      prev = val;
      if (fsm_switch()) init_code = next_code(init_code);
    end
    checks++;
    if (last_cnt != 4) begin
      errors++; $display("FAIL last_width got=%0d exp=%0d", last_cnt, 4);
    end
    checks++;
    if (g1 < 0 || g2 < 0 || (g2 - g1) != 36) begin
      errors++; $display("FAIL loop_period got=%0d exp=%0d", g2 - g1, 36);
    end
  endtask

  task automatic test_pause();
    int snap;
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++; $display("FAIL pause_seek cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
      if (fsm_switch()) init_code = next_code(init_code);
      if (m_mode == M_RUN && m_sec == 1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL pause_timeout got=%0d exp=%0d", 0, 1);
    end
    snap = m_rem;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (dut_bus !== exp_bus() || val !== 8'(snap) || {pre_last, tick, last} !== 3'b000) begin
        errors++; $display("FAIL pause_hold cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
    end
    en = 1'b1;
    step();
    step();
    checks++;
    if (pre_last !== 1'b1 || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL resume_pre_last got=%h exp=%h", dut_bus, exp_bus());
    end
  endtask

  task automatic test_init_err_restart();
    int pulses;
    pulses = 0;
    init_code = 3'b011; restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (val !== 8'd4 || err !== 1'b1 || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL bad_code_load got=%h exp=%h", dut_bus, exp_bus());
    end
    pulses = 1;
    init_code = 3'b001;
    for (int i = 0; i < 6; i++) begin
      step();
      if (err) pulses++;
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++; $display("FAIL bad_code_run cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL err_pulse_count got=%0d exp=%0d", pulses, 1);
    end
    init_code = 3'b010; restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (val !== 8'(YT) || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL restart_reload got=%h exp=%h", dut_bus, exp_bus());
    end
    restart = 1'b1; en = 1'b0; init_code = 3'b100;
    step();
    restart = 1'b0;
    step();
    checks++;
    if (val !== 8'(RT) || {pre_last, tick, last} !== 3'b000 || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL restart_pause got=%h exp=%h", dut_bus, exp_bus());
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) step();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_bus !== 12'h000) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", dut_bus, 12'h000);
    end
    en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (dut_bus !== 12'h000 || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL post_reset_idle got=%h exp=%h", dut_bus, 12'h000);
    end
    en = 1'b1; init_code = 3'b001;
    step();
    checks++;
    if (val !== 8'd3 || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL reset_restart got=%h exp=%h", dut_bus, exp_bus());
    end
  endtask

  task automatic test_ped();
    bit found;
    found = 0;
    init_code = 3'b100; restart = 1'b1;
    step();
    restart = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (m_mode == M_RUN && m_rem == 3 && m_sec == 0) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL ped_timeout got=%0d exp=%0d", 0, 1);
    end
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    checks++;
    if (val !== 8'(EXT_VAL) || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL ped_extend got=%0d exp=%0d", val, EXT_VAL);
    end
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    checks++;
    if (val !== 8'(EXT_VAL) || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL ped_second got=%0d exp=%0d", val, EXT_VAL);
    end
    init_code = 3'b001; restart = 1'b1;
    step();
    restart = 1'b0;
    step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    checks++;
    if (val !== 8'd3 || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL ped_green got=%0d exp=%0d", val, 3);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      restart = ($urandom_range(0, 39) == 0);
      ped_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) init_code = 3'($urandom_range(0, 7));
      step();
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_bus, exp_bus());
      end
      if (fsm_switch()) init_code = next_code(init_code);
      else if (!code_ok(init_code) && $urandom_range(0, 1) == 0) init_code = 3'b001;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=%0d exp=%0d", cyc, 0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_phase_loop();
    test_pause();
    test_init_err_restart();
    test_async_reset();
    test_ped();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
